// File: rtl/booth_mult.sv
// Radix-2 Booth 6x6 signed multiplier: result 6 clk edges after load, load restarts at any time.
// Also a free-running clk/2^DIV_BITS divider; BOOTH_PRODUCT_HOLD_EN registers product at completion.
module booth_mult #(
  parameter int DIV_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        slow_clk,
  output logic [11:0] product
);

  logic [6:0]          acc;
  logic [5:0]          mplr;
  logic [6:0]          mcand;
  logic                q_1;
  logic [2:0]          cnt;
  logic [DIV_BITS-1:0] div_cnt;

  logic [6:0]          sum;
  logic [6:0]          acc_nxt;
  logic [5:0]          mplr_nxt;

  // Seven-bit accumulator keeps A-M exact when the multiplicand is -32.
  always_comb begin
    sum = acc;
    case ({mplr[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt  = {sum[6], sum[6:1]};
    mplr_nxt = {sum[0], mplr[5:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mplr  <= b;
      mcand <= {a[5], a};
      q_1   <= 1'b0;
      cnt   <= 3'd6;
    end else if (cnt != 3'd0) begin
      acc   <= acc_nxt;
      mplr  <= mplr_nxt;
      q_1   <= mplr[0];
      cnt   <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + {{(DIV_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign slow_clk = div_cnt[DIV_BITS-1];

`ifdef BOOTH_PRODUCT_HOLD_EN
  logic [11:0] prod_r;

  // Captured on the final step so the output never shows partial sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r <= '0;
    end else if (!load && cnt == 3'd1) begin
      prod_r <= {acc_nxt[5:0], mplr_nxt};
    end
  end

  assign product = prod_r;
`else
  assign product = {acc[5:0], mplr};
`endif

endmodule

// File: tb/tb_booth_mult.sv
// Bench for booth_mult: directed vector table, multi-cycle corner sequences, random ops vs a*b model.
module tb_booth_mult;

  logic        clk;
  logic        rst;
  logic        load;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        slow_clk;
  logic [11:0] product;

  int n_cmp;
  int n_fail;
  logic [11:0] prev_result;

  typedef struct {
    logic [5:0]  va;
    logic [5:0]  vb;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  booth_mult #(.DIV_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .a        (a),
    .b        (b),
    .slow_clk (slow_clk),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_mul(input logic [5:0] x, input logic [5:0] y);
    int sx;
    int sy;
    int p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = sx * sy;
    return 12'(p);
  endfunction

  // Called at a negedge; returns at the negedge right after the load edge.
  task automatic do_load(input logic [5:0] va, input logic [5:0] vb);
    load = 1'b1;
    a    = va;
    b    = vb;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] va, input logic [5:0] vb,
                        input logic [11:0] exp);
    logic [11:0] done_val;
    do_load(va, vb);
`ifdef BOOTH_PRODUCT_HOLD_EN
    check({name, "_hold_start"}, product, prev_result);
    repeat (5) @(negedge clk);
    check({name, "_hold_step5"}, product, prev_result);
    @(negedge clk);
`else
    repeat (6) @(negedge clk);
`endif
    check(name, product, exp);
    done_val = product;
    prev_result = exp;
    // Operands changing while idle must not disturb the result.
    a = 6'($urandom);
    b = 6'($urandom);
    repeat (2) @(negedge clk);
    check({name, "_idle_hold"}, product, done_val);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    prev_result = '0;
    load = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b0;

    vecs[0] = '{6'd1,  6'd3,  12'h003};
    vecs[1] = '{6'h3F, 6'd3,  12'hFFD};
    vecs[2] = '{6'h20, 6'h20, 12'h400};
    vecs[3] = '{6'd31, 6'h20, 12'hC20};
    vecs[4] = '{6'd0,  6'd31, 12'h000};
    vecs[5] = '{6'd31, 6'd31, 12'h3C1};
    vecs[6] = '{6'h3F, 6'h3F, 12'h001};
    vecs[7] = '{6'h20, 6'd31, 12'hC20};

    repeat (3) @(negedge clk);
    check("reset_product", product, 12'h000);
    check("reset_slow_clk", {11'd0, slow_clk}, 12'h000);

    // Divider from release: slow_clk high on edges 8..15 modulo 16, regardless of load activity.
    rst = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      load = 1'($urandom);
      a = 6'($urandom);
      b = 6'($urandom);
      @(negedge clk);
      check($sformatf("slow_clk_edge%0d", k), {11'd0, slow_clk}, {11'd0, ((k % 16) >= 8)});
    end
    load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", product, 12'h000);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp);
    end

    // Abort: second load after three steps wins; 5*7 never completes.
    do_load(6'd5, 6'd7);
    repeat (3) @(negedge clk);
    do_load(6'h3A, 6'd4);
    for (int s = 1; s <= 6; s++) begin
      if (s < 6) check($sformatf("abort_no35_step%0d", s), (product == 12'd35) ? 12'd1 : 12'd0, 12'd0);
      @(negedge clk);
    end
    check("abort_restart", product, 12'hFE8);
    repeat (4) @(negedge clk);
    check("abort_no35_after", product, 12'hFE8);
    prev_result = 12'hFE8;

    // Reset mid-operation.
    do_load(6'd9, 6'd9);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_rst_product", product, 12'h000);
    check("midop_rst_slow_clk", {11'd0, slow_clk}, 12'h000);
    @(negedge clk);
    rst = 1'b1;
    prev_result = '0;
    repeat (8) @(negedge clk);
    check("midop_rst_idle", product, 12'h000);
    run_op("after_rst", 6'd2, 6'h3D, 12'hFFA);

    for (int i = 0; i < 150; i++) begin
      logic [5:0] ra;
      logic [5:0] rb;
      ra = 6'($urandom);
      rb = 6'($urandom_range(63, 0));
      run_op($sformatf("rand%0d_%0d_%0d", i, $signed(ra), $signed(rb)), ra, rb, ref_mul(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The module SHALL have one parameter line: DIV_BITS, default 4, width of the free-running divider counter that generates slow_clk.
REQ-002 The module SHALL have one clock and one reset: reset is asynchronous and active-low; clock port clk, reset port rst.
REQ-003 Port clk SHALL be: input, 1 bit, system clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port load SHALL be: input, 1 bit, synchronous start/load strobe.
REQ-006 Port a SHALL be: input, 6 bits, signed two's-complement multiplicand.
REQ-007 Port b SHALL be: input, 6 bits, signed two's-complement multiplier.
REQ-008 Port slow_clk SHALL be: output, 1 bit, divided clock equal to the MSB of the divider counter.
REQ-009 Port product SHALL be: output, 12 bits, signed two's-complement result a*b.

Function
REQ-010 The module SHALL implement radix-2 Booth multiplication with registers:
- A: 7-bit accumulator.
- Q: 6-bit multiplier.
- M: 7-bit sign-extended multiplicand.
- Q_1: 1 bit.
- cnt: 3-bit step counter.
REQ-011 On a rising clk with load=1, the module SHALL set A=0, Q=b, M=sign-extend(a), Q_1=0, cnt=6; no arithmetic step occurs on that edge.
REQ-012 On a rising clk with load=0 and cnt>0, the module SHALL perform one step:
- {Q[0],Q_1}=01: A=A+M.
- {Q[0],Q_1}=10: A=A-M.
- 00 or 11: A unchanged.
- Then arithmetic-shift-right {A,Q,Q_1} by one (A MSB replicated).
- Then cnt=cnt-1.
REQ-013 With cnt=0 and load=0, the module SHALL hold all datapath registers.
REQ-014 The final product SHALL equal {A[5:0],Q} after exactly 6 step edges following the load edge, i.e. valid after the 6th rising clk after the load edge.
REQ-015 The result SHALL be exact for all 4096 input pairs, including -32*-32=+1024 and -32*31=-992; the 7-bit A prevents overflow when M=-32.
REQ-016 load=1 while cnt>0 SHALL abort the current operation and restart with the new a and b (load has priority).
REQ-017 Changes on a and b while load=0 SHALL have no effect.
REQ-018 The divider counter SHALL increment every rising clk and wrap from all-ones to 0; slow_clk SHALL be the counter MSB (clk/2^DIV_BITS, 50% duty cycle).
REQ-019 slow_clk SHALL be independent of load and of multiplier state.

Reset
REQ-020 While rst=0, the module SHALL asynchronously force A, Q, M, Q_1, cnt, the divider counter and any product register to 0; product=0 and slow_clk=0.
REQ-021 After rst deasserts, the module SHALL stay idle (cnt=0, product=0) until the first load.
REQ-022 Reset asserted mid-operation SHALL abandon the operation; no partial result survives.

Configuration
REQ-023 The module SHALL support the macro BOOTH_PRODUCT_HOLD_EN.
REQ-024 Without BOOTH_PRODUCT_HOLD_EN, product SHALL combinationally reflect {A[5:0],Q} at all times, so partial values are visible during the 6 steps.
REQ-025 With BOOTH_PRODUCT_HOLD_EN, product SHALL be a 12-bit register:
- Written with the final value on the edge where cnt goes 1->0.
- Holds its previous result through load and through the steps.
- Reset to 0.

Verification
REQ-026 The bench SHALL cover reset then load a=1, b=3 -> product=3 (0x003) six clk edges after the load edge.
REQ-027 The bench SHALL cover load a=-1 (0x3F), b=3 -> product=-3 (0xFFD) after 6 steps.
REQ-028 The bench SHALL cover load a=-32, b=-32 -> product=+1024 (0x400); load a=31, b=-32 -> product=-992 (0xC20).
REQ-029 The bench SHALL cover load a=5, b=7, then after 3 steps load a=-6, b=4 -> product=-24 (0xFE8) six edges after the second load; the first result is never produced.
REQ-030 The bench SHALL cover rst pulsed low mid-operation -> product=0, slow_clk=0 immediately; the next load a=2, b=-3 -> product=-6 (0xFFA).
REQ-031 The bench SHALL cover free-running clk with DIV_BITS=4 -> slow_clk toggles every 8 clk edges, first rises on the 8th edge after reset release; with BOOTH_PRODUCT_HOLD_EN defined, product holds the prior result until completion.
